tdm_demux: RTL and testbench

//  Receive end of the 4-lane 1-bit time-division link whose transmit end is the
//  2-bit-select 4:1 mux. Drives the slot select back to that mux and samples its

---
 rtl/tdm_demux_pkg.sv | 13 +
 rtl/tdm_slot_ctr.sv | 27 ++
 rtl/tdm_demux.sv | 84 ++++++++
 tb/tb_tdm_demux.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM mux/demux pair: default lane geometry and
// the receive-side FSM state encoding.
package tdm_demux_pkg;

  localparam int LANES_DEF = 4;
  localparam int SEL_W_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// SEL_W-bit wrapping slot counter. load0 forces the effective slot to 0 this
// cycle so a frame start is honoured without waiting for the register.
module tdm_slot_ctr #(
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load0,
  output logic [SEL_W-1:0] slot_eff,
  output logic [SEL_W-1:0] slot
);

  localparam logic [SEL_W-1:0] ONE = {{(SEL_W-1){1'b0}}, 1'b1};

  assign slot_eff = load0 ? '0 : slot;

  // Power-of-two lane count, so natural overflow gives the LANES-1 -> 0 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (en) begin
      slot <= slot_eff + ONE;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Receive end of the 1-bit TDM link: drives the slot select to the remote mux,
// samples one bit per slot and publishes each complete frame as a parallel word.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             din,
  output logic [SEL_W-1:0] sel_out,
  output logic [LANES-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err,
  output tdm_state_e       dbg_state
);

  // Output protocol: dout_valid is a one-cycle strobe with no back-pressure;
  // dout is valid while dout_valid is high and holds until the next frame.

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

  tdm_state_e       state, state_nxt;
  logic             load0;
  logic             capture;
  logic [SEL_W-1:0] slot_eff;
  logic [SEL_W-1:0] slot;
  logic [LANES-1:0] shadow;

  assign load0   = en & sync;
  assign capture = en & ((state == ST_RUN) | sync);

  tdm_slot_ctr #(.SEL_W(SEL_W)) u_slot_ctr (
    .clk      (clk),
    .rst      (rst),
    .en       (capture),
    .load0    (load0),
    .slot_eff (slot_eff),
    .slot     (slot)
  );

  assign sel_out   = slot_eff;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (capture) begin
      state_nxt = ST_RUN;
    end
  end

  // A sync landing mid-frame restarts capture at slot 0; the stale partial
  // bits in shadow are overwritten before the next word is published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= load0 & (state == ST_RUN) & (slot != '0);
      if (capture) begin
        shadow[slot_eff] <= din;
        if (slot_eff == LAST_SLOT) begin
          dout       <= {din, shadow[LANES-2:0]};
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed scenarios plus random traffic checked against
// a frame-level model built from a queue of received bits.
module tb_tdm_demux;
  import tdm_demux_pkg::*;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             sync = 1'b0;
  logic             din = 1'b0;
  logic [SEL_W-1:0] sel_out;
  logic [LANES-1:0] dout;
  logic             dout_valid;
  logic             frame_err;
  tdm_state_e       dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the frame in progress, last published word,
  // and the scoreboard of words still expected on dout_valid.
  bit               m_run = 1'b0;
  bit               frame_q[$];
  logic [LANES-1:0] m_dout = '0;
  logic [LANES-1:0] exp_q[$];

  tdm_demux #(.LANES(LANES), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync       (sync),
    .din        (din),
    .sel_out    (sel_out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic model_reset();
    m_run = 1'b0;
    frame_q.delete();
    m_dout = '0;
    exp_q.delete();
  endtask

  // One link cycle. With loop set, din is taken from a tb-side 4:1 mux
  // addressed by the DUT's sel_out.
  task automatic step(input logic e, input logic s, input logic d,
                      input bit loop, input logic [LANES-1:0] lb_a);
    logic [SEL_W-1:0] exp_sel;
    logic             exp_valid;
    logic             exp_err;
    logic             dd;
    logic [LANES-1:0] w;
    tdm_state_e       exp_state;
    @(negedge clk);
    en = e;
    sync = s;
    #1;
    dd = loop ? lb_a[sel_out] : d;
    din = dd;
    #1;
    exp_sel = (e && s) ? '0 : SEL_W'(frame_q.size());
    checks++;
    if (sel_out !== exp_sel) begin
      errors++;
      $display("FAIL sel_out got %0d expected %0d at %0t", sel_out, exp_sel, $time);
    end
    exp_valid = 1'b0;
    exp_err = 1'b0;
    if (e && (m_run || s)) begin
      if (s) begin
        if (frame_q.size() != 0) exp_err = 1'b1;
        frame_q.delete();
      end
      frame_q.push_back(dd);
      m_run = 1'b1;
      if (frame_q.size() == LANES) begin
        w = '0;
        for (int k = 0; k < LANES; k++) w[k] = frame_q[k];
        frame_q.delete();
        m_dout = w;
        exp_valid = 1'b1;
        exp_q.push_back(w);
      end
    end
    exp_state = m_run ? ST_RUN : ST_IDLE;
    @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== exp_valid) begin
      errors++;
      $display("FAIL dout_valid got %b expected %b at %0t", dout_valid, exp_valid, $time);
    end
    checks++;
    if (frame_err !== exp_err) begin
      errors++;
      $display("FAIL frame_err got %b expected %b at %0t", frame_err, exp_err, $time);
    end
    checks++;
    if (dout !== m_dout) begin
      errors++;
      $display("FAIL dout got %b expected %b at %0t", dout, m_dout, $time);
    end
    checks++;
    if (dbg_state !== exp_state) begin
      errors++;
      $display("FAIL state got %0d expected %0d at %0t", dbg_state, exp_state, $time);
    end
    if (dout_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard unexpected word %b at %0t", dout, $time);
      end else begin
        w = exp_q.pop_front();
        if (dout !== w) begin
          errors++;
          $display("FAIL scoreboard word got %b expected %b", dout, w);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({sel_out, dout, dout_valid, frame_err} !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL %s sel=%0d dout=%b valid=%b err=%b state=%0d expected all zero/IDLE",
               tag, sel_out, dout, dout_valid, frame_err, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    sync = 1'b1;
    din = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    sync = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic test_single_frame();
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (dout !== 4'b1101) begin
      errors++;
      $display("FAIL single_frame dout got %b expected 1101", dout);
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_frame");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    sync = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_continuous();
    logic [LANES-1:0] words [3];
    words[0] = 4'hA;
    words[1] = 4'h5;
    words[2] = 4'hF;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < LANES; k++) begin
        step(1'b1, (f == 0 && k == 0), words[f][k], 1'b0, '0);
      end
      checks++;
      if (dout !== words[f]) begin
        errors++;
        $display("FAIL continuous frame %0d got %h expected %h", f, dout, words[f]);
      end
    end
  endtask

  task automatic test_misaligned_sync();
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (dout !== 4'b0110) begin
      errors++;
      $display("FAIL misaligned dout got %b expected 0110", dout);
    end
  endtask

  task automatic test_enable_gap();
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (dout !== 4'b1010) begin
      errors++;
      $display("FAIL enable_gap dout got %b expected 1010", dout);
    end
  endtask

  task automatic test_loopback();
    logic [LANES-1:0] a;
    a = 4'b0110;
    for (int i = 0; i < 3 * LANES; i++) begin
      step(1'b1, (i == 0), 1'b0, 1'b1, a);
      if ((i % LANES) == LANES - 1) begin
        checks++;
        if (dout !== 4'b0110) begin
          errors++;
          $display("FAIL loopback frame %0d got %b expected 0110", i / LANES, dout);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 1)), 1'b0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_reset_mid_frame();
    test_continuous();
    test_misaligned_sync();
    test_enable_gap();
    test_loopback();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard %0d words never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
